// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the execute stage: one quotient bit per
// cycle, sign fix-up afterwards, results registered and held until the next op.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]    ONE_C    = {{(CW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        return ~v + ONE_W;
    endfunction

    function automatic logic [WIDTH-1:0] abs_w(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? neg_w(v) : v;
    endfunction

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_quo_q, sign_quo_d;
    logic             sign_rem_q, sign_rem_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   diff_s;

    // The partial remainder keeps its MSB so divisors above 2^(W-1) still work.
    always_comb begin
        shift_s = {rem_q, quo_q[WIDTH-1]};
        diff_s  = shift_s - {1'b0, dvs_q};
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sign_quo_d  = sign_quo_q;
        sign_rem_d  = sign_rem_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start && (divisor == ZERO_W)) begin
                    quotient_d  = ONES_W;
                    remainder_d = dividend;
                    dbz_d       = 1'b1;
                    done_d      = 1'b1;
                    state_d     = S_DONE;
                end else if (start) begin
                    sign_quo_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    sign_rem_d = is_signed & dividend[WIDTH-1];
                    quo_d      = abs_w(dividend, is_signed);
                    dvs_d      = abs_w(divisor, is_signed);
                    rem_d      = ZERO_W;
                    count_d    = CNT_LAST;
                    busy_d     = 1'b1;
                    state_d    = S_DIV;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                if (!diff_s[WIDTH]) begin
                    rem_d = diff_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = shift_s[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (count_q == CNT_ZERO) begin
                    state_d = S_FIX;
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
            S_FIX: begin
                quotient_d  = sign_quo_q ? neg_w(quo_q) : quo_q;
                remainder_d = sign_rem_q ? neg_w(rem_q) : rem_q;
                dbz_d       = 1'b0;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and result registers; reset abandons any divide in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= CNT_ZERO;
            rem_q       <= ZERO_W;
            quo_q       <= ZERO_W;
            dvs_q       <= ZERO_W;
            sign_quo_q  <= 1'b0;
            sign_rem_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= ZERO_W;
            remainder_q <= ZERO_W;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sign_quo_q  <= sign_quo_d;
            sign_rem_q  <= sign_rem_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign stall       = busy_q | (start & (state_q == S_IDLE));
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, signed/unsigned results, divide by zero,
// reset abort and back-to-back operation with start held high.
module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, is_signed;
    logic [W-1:0] dividend, divisor;
    logic         busy, stall, done, div_by_zero;
    logic [W-1:0] quotient, remainder;

    int n_vec = 0;
    int n_err = 0;

    div_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .stall(stall),
        .done(done), .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    // Launch one divide; report edges-to-done (start edge counts as 1),
    // cycles busy/stall were high, and the held results.
    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                          output int edges, output int busy_n, output int stall_n,
                          output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        edges = 0; busy_n = 0; stall_n = 0;
        @(negedge clk);
        dividend = a; divisor = b; is_signed = sgn; start = 1'b1;
        #1;
        if (stall) stall_n++;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            edges++;
            if (busy) busy_n++;
            if (stall) stall_n++;
            if (done) break;
        end
        if (!done) edges = -1;
        q = quotient; r = remainder; z = div_by_zero;
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, div_by_zero, quotient, remainder} !== {3'b000, {W{1'b0}}, {W{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b dbz=%b q=%h r=%h, required all zero",
                     busy, done, div_by_zero, quotient, remainder);
        end
        reset = 1'b0;
    endtask

    task automatic check_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic sgn, input logic [W-1:0] eq, input logic [W-1:0] er,
                             input logic ez, input int e_edges);
        int e, bn, sn; logic [W-1:0] q, r; logic z;
        do_div(a, b, sgn, e, bn, sn, q, r, z);
        n_vec++;
        if (e !== e_edges) begin
            n_err++;
            $display("FAIL %s_latency: edges=%0d, required %0d", name, e, e_edges);
        end
        n_vec++;
        if ({q, r, z} !== {eq, er, ez}) begin
            n_err++;
            $display("FAIL %s_result: q=%h r=%h dbz=%b, required q=%h r=%h dbz=%b",
                     name, q, r, z, eq, er, ez);
        end
    endtask

    task automatic test_unsigned_timing;
        int e, bn, sn; logic [W-1:0] q, r; logic z;
        do_div(32'd100, 32'd7, 1'b0, e, bn, sn, q, r, z);
        n_vec++;
        if (e !== 34) begin n_err++; $display("FAIL u100_7_latency: edges=%0d, required 34", e); end
        n_vec++;
        if (bn !== 33) begin n_err++; $display("FAIL u100_7_busy: cycles=%0d, required 33", bn); end
        n_vec++;
        if (sn !== 34) begin n_err++; $display("FAIL u100_7_stall: cycles=%0d, required 34", sn); end
        n_vec++;
        if ({q, r} !== {32'd14, 32'd2}) begin
            n_err++; $display("FAIL u100_7_result: q=%h r=%h, required q=0000000e r=00000002", q, r);
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: done=%b, required 0", done); end
    endtask

    task automatic test_results;
        check_div("s_m100_7",   32'hFFFFFF9C, 32'd7,        1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34);
        check_div("u_ff9c_7",   32'hFFFFFF9C, 32'd7,        1'b0, 32'h24924916, 32'd2,        1'b0, 34);
        check_div("s_7_m2",     32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        1'b0, 34);
        check_div("s_ovf",      32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        1'b0, 34);
        check_div("u_max_1",    32'hFFFFFFFF, 32'd1,        1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 34);
        check_div("u_msb_dvs",  32'hFFFFFFFF, 32'h80000001, 1'b0, 32'd1,        32'h7FFFFFFE, 1'b0, 34);
    endtask

    task automatic test_div_by_zero;
        int e, bn, sn; logic [W-1:0] q, r; logic z;
        do_div(32'h12345678, 32'd0, 1'b1, e, bn, sn, q, r, z);
        n_vec++;
        if (e !== 1) begin n_err++; $display("FAIL dbz_latency: edges=%0d, required 1", e); end
        n_vec++;
        if (bn !== 0) begin n_err++; $display("FAIL dbz_busy: cycles=%0d, required 0", bn); end
        n_vec++;
        if (sn !== 1) begin n_err++; $display("FAIL dbz_stall: cycles=%0d, required 1", sn); end
        n_vec++;
        if ({q, r, z} !== {32'hFFFFFFFF, 32'h12345678, 1'b1}) begin
            n_err++; $display("FAIL dbz_result: q=%h r=%h dbz=%b, required ffffffff 12345678 1", q, r, z);
        end
        repeat (2) @(negedge clk);
        n_vec++;
        if (div_by_zero !== 1'b1) begin n_err++; $display("FAIL dbz_hold: dbz=%b, required 1", div_by_zero); end
        check_div("dbz_clear", 32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0, 34);
    endtask

    task automatic test_reset_mid_div;
        bit seen = 0;
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({busy, stall, done} !== 3'b000) begin
            n_err++; $display("FAIL reset_abort: busy=%b stall=%b done=%b, required 000", busy, stall, done);
        end
        n_vec++;
        if (quotient !== 32'd0) begin n_err++; $display("FAIL reset_abort_q: q=%h, required 0", quotient); end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL reset_no_done: done pulsed=1, required 0"); end
    endtask

    task automatic test_back_to_back;
        int t1, t2, n;
        logic [W-1:0] q1, r1;
        t1 = -1; t2 = -1; n = 0; q1 = '0; r1 = '0;
        @(negedge clk);
        dividend = 32'd200; divisor = 32'd9; is_signed = 1'b0; start = 1'b1;
        for (int i = 1; i <= 120 && t2 < 0; i++) begin
            @(negedge clk);
            if (i == 5) begin dividend = 32'd77; divisor = 32'd4; end
            if (done && t1 < 0) begin t1 = i; q1 = quotient; r1 = remainder; end
            else if (done) t2 = i;
        end
        start = 1'b0;
        n_vec++;
        if ({q1, r1} !== {32'd22, 32'd2}) begin
            n_err++; $display("FAIL b2b_first: q=%h r=%h, required q=00000016 r=00000002", q1, r1);
        end
        n_vec++;
        if (t1 !== 34) begin n_err++; $display("FAIL b2b_first_latency: edges=%0d, required 34", t1); end
        n_vec++;
        if (t2 - t1 !== 35) begin n_err++; $display("FAIL b2b_gap: edges=%0d, required 35", t2 - t1); end
        n_vec++;
        if ({quotient, remainder} !== {32'd19, 32'd1}) begin
            n_err++; $display("FAIL b2b_second: q=%h r=%h, required q=00000013 r=00000001", quotient, remainder);
        end
    endtask

    initial begin
        test_reset;
        test_unsigned_timing;
        test_results;
        test_div_by_zero;
        test_reset_mid_div;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
